// File: rtl/pwm_pkg.sv
// Shared constants, configuration payload and helpers for the PWM output block.
package pwm_pkg;

  localparam int unsigned NUM_CH          = 16;
  localparam int unsigned CNT_W           = 8;
  localparam logic [7:0]  DUTY_MAX        = 8'hFF;
  localparam int unsigned CLK_DIV_DEFAULT = 13;

  // Complete channel configuration as assembled from the five SPI bytes
  typedef struct packed {
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
    logic [CNT_W-1:0]  duty;
  } pwm_cfg_t;

  // Prescaler width for a given division ratio, never narrower than one bit
  function automatic int unsigned pre_width(input int unsigned div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus free-running 8-bit period counter shared by PWM/timer blocks.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             tick,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam int unsigned    PRE_W    = pre_width(CLK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  if ((CLK_DIV < 1) || (CLK_DIV > 256)) begin : g_bad_div
    $error("pwm_timebase: CLK_DIV must be in 1..256");
  end

  logic [PRE_W-1:0] pre_q;
  logic [CNT_W-1:0] cnt_q;

  // Counter advances on the last prescaler step; with CLK_DIV=1 pre stays 0 so tick is always 1
  assign tick = (pre_q == PRE_LAST);
  assign cnt  = cnt_q;
  assign wrap = tick && (&cnt_q);

  // Prescaler counts 0..CLK_DIV-1 and wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  // Period counter rolls 255 -> 0 with no terminal state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel output stage: each pin forced low, forced high, or fed by a shared PWM.
// Define PWM_SHADOW_EN to apply configuration changes only at period boundaries.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        en_reg_out_7_0,
  input  logic [7:0]        en_reg_out_15_8,
  input  logic [7:0]        en_reg_pwm_7_0,
  input  logic [7:0]        en_reg_pwm_15_8,
  input  logic [7:0]        pwm_duty_cycle,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  logic             tick;
  logic [CNT_W-1:0] cnt;
  logic             wrap;
  pwm_cfg_t         live_cfg;
  pwm_cfg_t         eff_cfg;
  logic             pwm_level_c;
  logic [NUM_CH-1:0] out_c;
  logic             start_q;

  pwm_timebase #(
    .CLK_DIV(CLK_DIV)
  ) u_timebase (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .cnt  (cnt),
    .wrap (wrap)
  );

  assign live_cfg.en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign live_cfg.en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign live_cfg.duty   = pwm_duty_cycle;

`ifdef PWM_SHADOW_EN
  pwm_cfg_t shadow_q;

  // Snapshot all configuration on the edge entering cnt=0 so no period is torn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (tick && (&cnt)) begin
      shadow_q <= live_cfg;
    end
  end

  assign eff_cfg = shadow_q;
`else
  logic unused_tick;

  assign unused_tick = tick;
  assign eff_cfg     = live_cfg;
`endif

  // Shared PWM level; full scale is held high so 0xFF never dips at cnt=255
  always_comb begin
    pwm_level_c = 1'b0;
    if (eff_cfg.duty == DUTY_MAX) begin
      pwm_level_c = 1'b1;
    end else begin
      pwm_level_c = (cnt < eff_cfg.duty);
    end
  end

  // Enable dominates; selected channels follow PWM, the rest are driven high
  always_comb begin
    out_c = eff_cfg.en_out & (~eff_cfg.en_pwm | {NUM_CH{pwm_level_c}});
  end

  // Output pins and the period marker, aligned so period_start coincides with cnt=0 on out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= '0;
      start_q      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      out          <= out_c;
      start_q      <= wrap;
      period_start <= start_q;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral against a cycle-position reference model.
module tb_pwm_peripheral;

  localparam int DIV = 2;
  localparam int P   = 256 * DIV;

  typedef struct packed {
    logic [15:0] eo;
    logic [15:0] ep;
    logic [7:0]  d;
  } cfg_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [15:0] dut_out;
  logic        period_start;

  int checks = 0;
  int errors = 0;

  logic [15:0] q_out[$];
  logic        q_ps[$];

  pwm_peripheral #(
    .CLK_DIV(DIV)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_reg_out_7_0 (en_out[7:0]),
    .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0 (en_pwm[7:0]),
    .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle (duty),
    .out            (dut_out),
    .period_start   (period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    en_out = eo;
    en_pwm = ep;
    duty   = d;
  endtask

  // Advance to the next cycle showing period_start; n = samples taken, 0 on timeout
  task automatic count_to_ps(output int n);
    bit found;
    found = 0;
    n = 0;
    while (!found && n < 2 * P + 4) begin
      @(posedge clk); #1;
      n++;
      if (period_start === 1'b1) found = 1;
    end
    if (!found) n = 0;
  endtask

  task automatic wait_ps();
    int n;
    count_to_ps(n);
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL wait_period_start: got timeout expected pulse at %0t", $time);
    end
  endtask

  // Called on a period_start sample; counts out[0] high samples across one period
  task automatic measure_hi(input int change_at, input logic [7:0] nd,
                            output int hi, output logic first);
    hi = 0;
    first = dut_out[0];
    for (int i = 0; i < P; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (dut_out[0] === 1'b1) hi++;
      if (i == change_at) duty = nd;
    end
  endtask

  // Reference model: output after edge k shows position (k-1) mod P of the period
  initial begin : model
    int   k;
    int   p;
    cfg_t cur;
    cfg_t eff;
    logic lvl;
    logic [15:0] e;
`ifdef PWM_SHADOW_EN
    cfg_t shadow;
    shadow = '0;
`endif
    k = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k = 0;
`ifdef PWM_SHADOW_EN
        shadow = '0;
`endif
        q_out.push_back(16'h0000);
        q_ps.push_back(1'b0);
      end else begin
        k++;
        p   = (k - 1) % P;
        cur = {en_out, en_pwm, duty};
`ifdef PWM_SHADOW_EN
        eff = shadow;
`else
        eff = cur;
`endif
        lvl = (eff.d == 8'hFF) || (p < int'(eff.d) * DIV);
        for (int ch = 0; ch < 16; ch++) begin
          e[ch] = eff.eo[ch] ? (eff.ep[ch] ? lvl : 1'b1) : 1'b0;
        end
        q_out.push_back(e);
        q_ps.push_back((p == 0) && (k > P));
`ifdef PWM_SHADOW_EN
        if (k % P == 0) shadow = cur;
`endif
      end
    end
  end

  // Monitor: every cycle the DUT presents out/period_start, compare with the queue head
  initial begin : monitor
    logic [15:0] eo;
    logic        eps;
    forever begin
      @(posedge clk); #1;
      if (q_out.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
      end else begin
        eo  = q_out.pop_front();
        eps = q_ps.pop_front();
        chk("sb_out", dut_out, eo);
        chk("sb_period_start", period_start, eps);
      end
    end
  end

  initial begin : stim
    int          n;
    int          hi;
    int          nz;
    logic        first;
    logic [7:0]  duties[6];

    rst_n = 1'b0;
    set_cfg(16'h0000, 16'h0000, 8'h00);
    repeat (3) @(negedge clk);
    chk("reset_out", dut_out, 16'h0000);
    chk("reset_period_start", period_start, 1'b0);
    rst_n = 1'b1;

    // Static channels
    set_cfg(16'hFFFF, 16'h0000, 8'h00);
    repeat (2 * P + 2) @(negedge clk);
    chk("static_ffff", dut_out, 16'hFFFF);
    en_out = 16'h00F0;
    repeat (P + 2) @(negedge clk);
    chk("static_00f0", dut_out, 16'h00F0);

    // Asynchronous reset mid-period
    set_cfg(16'hFFFF, 16'h0000, 8'h80);
    repeat (P + 37) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", dut_out, 16'h0000);
    chk("async_reset_ps", period_start, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_to_ps(n);
    chk("first_ps_edges_after_release", n, P + 1);
    count_to_ps(n);
    chk("ps_spacing", n, P);

    // Duty sweep including extremes
    duties[0] = 8'h40;
    duties[1] = 8'h00;
    duties[2] = 8'hFF;
    duties[3] = 8'h01;
    duties[4] = 8'hFE;
    duties[5] = 8'($urandom_range(2, 253));
    foreach (duties[j]) begin
      set_cfg(16'h0001, 16'h0001, duties[j]);
      wait_ps();
      wait_ps();
      measure_hi(-1, 8'h00, hi, first);
      chk($sformatf("duty_hi_%02h", duties[j]), hi,
          (duties[j] == 8'hFF) ? P : int'(duties[j]) * DIV);
      chk($sformatf("duty_first_%02h", duties[j]), first, duties[j] != 8'h00);
    end

    // Enable priority over PWM select
    set_cfg(16'h0000, 16'hFFFF, 8'h80);
    wait_ps();
    wait_ps();
    nz = 0;
    for (int i = 0; i < P; i++) begin
      if (dut_out !== 16'h0000) nz++;
      @(posedge clk); #1;
    end
    chk("enable_priority_nonzero_cycles", nz, 0);

    // Duty change written mid-period, around cnt=100
    set_cfg(16'h0001, 16'h0001, 8'h20);
    wait_ps();
    wait_ps();
    measure_hi(199, 8'hC0, hi, first);
`ifdef PWM_SHADOW_EN
    chk("shadow_current_period_hi", hi, 8'h20 * DIV);
`endif
    @(posedge clk); #1;
    chk("next_period_ps", period_start, 1'b1);
    measure_hi(-1, 8'h00, hi, first);
    chk("next_period_hi", hi, 8'hC0 * DIV);

    // Randomised configuration traffic with occasional resets
    repeat (30) begin
      @(negedge clk);
      n = $urandom_range(0, 3);
      set_cfg(16'($urandom), 16'($urandom),
              (n == 0) ? 8'h00 : (n == 1) ? 8'hFF : 8'($urandom));
      repeat ($urandom_range(1, 300)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_n = 1'b1;
      end
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
